// File: rtl/bram1be_arbiter2.sv
`default_nettype none
// ============================================================================
// bram1be_arbiter2
//   Round-robin arbiter that shares one byte-enabled BRAM port between two
//   clients and steers read data back through a latency-matched tag pipe.
//   Revision: 1.0
// ============================================================================
module bram1be_arbiter2 #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int WE_WIDTH   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_EN,
  input  logic [WE_WIDTH-1:0]   A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DI,
  output logic                  A_RDY,
  output logic                  A_RSP_VAL,
  output logic [DATA_WIDTH-1:0] A_RSP_DO,
  input  logic                  B_EN,
  input  logic [WE_WIDTH-1:0]   B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_DI,
  output logic                  B_RDY,
  output logic                  B_RSP_VAL,
  output logic [DATA_WIDTH-1:0] B_RSP_DO,
  output logic                  MEM_EN,
  output logic [WE_WIDTH-1:0]   MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DI,
  input  logic [DATA_WIDTH-1:0] MEM_DO
);

  localparam int c_lat = PIPELINED + 1;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  client_e          last_gnt_q, last_gnt_d;
  logic             gnt_a, gnt_b, issue_rd;
  logic [c_lat-1:0] vld_q, vld_d;
  logic [c_lat-1:0] own_q, own_d;  // 1 = client B owns the stage

  // On a tie the client that did not win last time gets the port.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      gnt_a = A_EN && (!B_EN || (last_gnt_q == CLIENT_B));
      gnt_b = B_EN && (!A_EN || (last_gnt_q == CLIENT_A));
    end
  end

  assign A_RDY = gnt_a;
  assign B_RDY = gnt_b;

  always_comb begin
    MEM_EN   = gnt_a | gnt_b;
    MEM_WE   = '0;
    MEM_ADDR = A_ADDR;
    MEM_DI   = A_DI;
    if (gnt_b) begin
      MEM_WE   = B_WE;
      MEM_ADDR = B_ADDR;
      MEM_DI   = B_DI;
    end else if (gnt_a) begin
      MEM_WE   = A_WE;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_a)      last_gnt_d = CLIENT_A;
    else if (gnt_b) last_gnt_d = CLIENT_B;
  end

  assign issue_rd = MEM_EN && (MEM_WE == '0);

  generate
    if (c_lat == 1) begin : g_lat_single
      assign vld_d = issue_rd;
      assign own_d = gnt_b;
    end else begin : g_lat_shift
      assign vld_d = {vld_q[c_lat-2:0], issue_rd};
      assign own_d = {own_q[c_lat-2:0], gnt_b};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt_q <= CLIENT_B;
      vld_q      <= '0;
      own_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
      own_q      <= own_d;
    end
  end

  // Data is unqualified without RSP_VAL, so both clients see the RAM output.
  assign A_RSP_VAL = !RST && vld_q[c_lat-1] && !own_q[c_lat-1];
  assign B_RSP_VAL = !RST && vld_q[c_lat-1] &&  own_q[c_lat-1];
  assign A_RSP_DO  = MEM_DO;
  assign B_RSP_DO  = MEM_DO;

endmodule
`default_nettype wire

// File: tb/tb_bram1be_arbiter2.sv
`default_nettype none
// ============================================================================
// tb_bram1be_arbiter2
//   Directed bench: two arbiters (read latency 1 and 2) share one stimulus,
//   each with its own byte-enabled RAM model.
//   Revision: 1.0
// ============================================================================
module tb_bram1be_arbiter2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, b_en;
  logic [1:0]  a_we, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_di, b_di;

  logic        d0_a_rdy, d0_a_val, d0_b_rdy, d0_b_val, d0_men;
  logic [15:0] d0_a_do, d0_b_do, d0_mdi, d0_mdo;
  logic [1:0]  d0_mwe;
  logic [3:0]  d0_maddr;
  logic        d1_a_rdy, d1_a_val, d1_b_rdy, d1_b_val, d1_men;
  logic [15:0] d1_a_do, d1_b_do, d1_mdi, d1_mdo;
  logic [1:0]  d1_mwe;
  logic [3:0]  d1_maddr;

  int n_tests = 0;
  int n_fail  = 0;

  bram1be_arbiter2 #(.PIPELINED(0), .ADDR_WIDTH(4), .DATA_WIDTH(16), .WE_WIDTH(2)) u_dut0 (
    .CLK(clk), .RST(rst),
    .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di),
    .A_RDY(d0_a_rdy), .A_RSP_VAL(d0_a_val), .A_RSP_DO(d0_a_do),
    .B_EN(b_en), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di),
    .B_RDY(d0_b_rdy), .B_RSP_VAL(d0_b_val), .B_RSP_DO(d0_b_do),
    .MEM_EN(d0_men), .MEM_WE(d0_mwe), .MEM_ADDR(d0_maddr), .MEM_DI(d0_mdi),
    .MEM_DO(d0_mdo)
  );

  bram1be_arbiter2 #(.PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(16), .WE_WIDTH(2)) u_dut1 (
    .CLK(clk), .RST(rst),
    .A_EN(a_en), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di),
    .A_RDY(d1_a_rdy), .A_RSP_VAL(d1_a_val), .A_RSP_DO(d1_a_do),
    .B_EN(b_en), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di),
    .B_RDY(d1_b_rdy), .B_RSP_VAL(d1_b_val), .B_RSP_DO(d1_b_do),
    .MEM_EN(d1_men), .MEM_WE(d1_mwe), .MEM_ADDR(d1_maddr), .MEM_DI(d1_mdi),
    .MEM_DO(d1_mdo)
  );

  // RAM image: word i holds {i,i}, except 0x0011 at 5 and 0x1234 at 3.
  function automatic logic [15:0] init_word(input int i);
    if (i == 5) return 16'h0011;
    if (i == 3) return 16'h1234;
    return {8'(i), 8'(i)};
  endfunction

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] ram1_stage;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem0[i] <= init_word(i);
    end else if (d0_men) begin
      if (|d0_mwe) begin
        for (int b = 0; b < 2; b++)
          if (d0_mwe[b]) mem0[d0_maddr][8*b +: 8] <= d0_mdi[8*b +: 8];
      end else begin
        d0_mdo <= mem0[d0_maddr];
      end
    end
  end

  always @(posedge clk) begin
    d1_mdo <= ram1_stage;
    if (rst) begin
      for (int i = 0; i < 16; i++) mem1[i] <= init_word(i);
    end else if (d1_men) begin
      if (|d1_mwe) begin
        for (int b = 0; b < 2; b++)
          if (d1_mwe[b]) mem1[d1_maddr][8*b +: 8] <= d1_mdi[8*b +: 8];
      end else begin
        ram1_stage <= mem1[d1_maddr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] t4_data [3];
  logic [2:0]  t4_isb;

  initial begin
    rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
    a_we = 2'b00; b_we = 2'b00; a_addr = 4'd0; b_addr = 4'd0;
    a_di = 16'h0; b_di = 16'h0;
    t4_data[0] = 16'h0101; t4_data[1] = 16'h0202; t4_data[2] = 16'h12EF;
    t4_isb = 3'b010;

    // 1: reset state, then single A read of address 5
    tick();
    a_en = 1'b1; a_addr = 4'd5;
    #1;
    check_eq("rst_mem_en",  32'(d0_men),   32'd0);
    check_eq("rst_a_rdy",   32'(d0_a_rdy), 32'd0);
    check_eq("rst_a_val",   32'(d0_a_val), 32'd0);
    check_eq("rst_b_val",   32'(d1_b_val), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t1_a_rdy",    32'(d0_a_rdy), 32'd1);
    check_eq("t1_b_rdy",    32'(d0_b_rdy), 32'd0);
    check_eq("t1_mem_en",   32'(d0_men),   32'd1);
    check_eq("t1_mem_addr", 32'(d0_maddr), 32'd5);
    tick();
    a_en = 1'b0;
    #1;
    check_eq("t1_d0_a_val", 32'(d0_a_val), 32'd1);
    check_eq("t1_d0_a_do",  32'(d0_a_do),  32'h0011);
    check_eq("t1_d0_b_val", 32'(d0_b_val), 32'd0);
    check_eq("t1_d1_early", 32'(d1_a_val), 32'd0);
    tick();
    check_eq("t1_d1_a_val", 32'(d1_a_val), 32'd1);
    check_eq("t1_d1_a_do",  32'(d1_a_do),  32'h0011);
    check_eq("t1_d0_once",  32'(d0_a_val), 32'd0);

    // 2: both clients hold read requests for 6 cycles -> A,B,A,B,A,B
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      a_en = (k < 6); b_en = (k < 6);
      a_addr = 4'd1; b_addr = 4'd2; a_we = 2'b00; b_we = 2'b00;
      #1;
      if (k < 6) begin
        check_eq($sformatf("t2_a_rdy_%0d", k), 32'(d0_a_rdy), 32'((k % 2) == 0));
        check_eq($sformatf("t2_b_rdy_%0d", k), 32'(d0_b_rdy), 32'((k % 2) == 1));
      end
      begin
        int  j0, j1;
        logic v0, v1;
        j0 = k - 1; j1 = k - 2;
        v0 = (j0 >= 0) && (j0 <= 5);
        v1 = (j1 >= 0) && (j1 <= 5);
        check_eq($sformatf("t2_d0_a_val_%0d", k), 32'(d0_a_val), 32'(v0 && (j0 % 2 == 0)));
        check_eq($sformatf("t2_d0_b_val_%0d", k), 32'(d0_b_val), 32'(v0 && (j0 % 2 == 1)));
        if (v0) check_eq($sformatf("t2_d0_do_%0d", k), 32'(d0_a_do),
                         (j0 % 2 == 0) ? 32'h0101 : 32'h0202);
        check_eq($sformatf("t2_d1_a_val_%0d", k), 32'(d1_a_val), 32'(v1 && (j1 % 2 == 0)));
        check_eq($sformatf("t2_d1_b_val_%0d", k), 32'(d1_b_val), 32'(v1 && (j1 % 2 == 1)));
        if (v1) check_eq($sformatf("t2_d1_do_%0d", k), 32'(d1_b_do),
                         (j1 % 2 == 0) ? 32'h0101 : 32'h0202);
      end
    end

    // 3: A writes low byte of address 3, then B reads it back
    tick();
    a_en = 1'b1; a_we = 2'b01; a_addr = 4'd3; a_di = 16'hBEEF;
    #1;
    check_eq("t3_a_rdy",  32'(d0_a_rdy), 32'd1);
    check_eq("t3_mem_we", 32'(d0_mwe),   32'h1);
    tick();
    a_en = 1'b0; a_we = 2'b00; b_en = 1'b1; b_addr = 4'd3;
    #1;
    check_eq("t3_b_rdy",       32'(d0_b_rdy), 32'd1);
    check_eq("t3_wr_no_rsp",   32'(d0_a_val), 32'd0);
    tick();
    b_en = 1'b0;
    #1;
    check_eq("t3_d0_b_val",    32'(d0_b_val), 32'd1);
    check_eq("t3_d0_b_do",     32'(d0_b_do),  32'h12EF);
    check_eq("t3_d0_a_val",    32'(d0_a_val), 32'd0);
    check_eq("t3_d1_wr_no_rsp",32'(d1_a_val), 32'd0);
    tick();
    check_eq("t3_d1_b_val",    32'(d1_b_val), 32'd1);
    check_eq("t3_d1_b_do",     32'(d1_b_do),  32'h12EF);
    check_eq("t3_d1_a_val",    32'(d1_a_val), 32'd0);

    // 4: back-to-back reads A@1, B@2, A@3 on the latency-2 instance
    for (int k = 0; k < 5; k++) begin
      tick();
      a_en = (k == 0) || (k == 2); b_en = (k == 1);
      a_addr = (k == 0) ? 4'd1 : 4'd3; b_addr = 4'd2;
      #1;
      begin
        int   j;
        logic v;
        j = k - 2;
        v = (j >= 0) && (j <= 2);
        check_eq($sformatf("t4_a_val_%0d", k), 32'(d1_a_val), 32'(v && !t4_isb[(j < 0) ? 0 : j]));
        check_eq($sformatf("t4_b_val_%0d", k), 32'(d1_b_val), 32'(v &&  t4_isb[(j < 0) ? 0 : j]));
        if (v) check_eq($sformatf("t4_do_%0d", k), 32'(d1_a_do), 32'(t4_data[j]));
      end
    end

    // 5: read, then reset the next cycle; the in-flight response must vanish
    tick();
    a_en = 1'b1; b_en = 1'b0; a_addr = 4'd5;
    #1;
    check_eq("t5_a_rdy",      32'(d0_a_rdy), 32'd1);
    tick();
    rst = 1'b1; a_en = 1'b1; b_en = 1'b1; a_addr = 4'd1; b_addr = 4'd2;
    #1;
    check_eq("t5_mem_en",     32'(d0_men),   32'd0);
    check_eq("t5_a_rdy_rst",  32'(d0_a_rdy), 32'd0);
    check_eq("t5_b_rdy_rst",  32'(d0_b_rdy), 32'd0);
    check_eq("t5_d0_a_val",   32'(d0_a_val), 32'd0);
    check_eq("t5_d1_a_val",   32'(d1_a_val), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t5_tie_a",      32'(d0_a_rdy), 32'd1);
    check_eq("t5_tie_b",      32'(d0_b_rdy), 32'd0);
    check_eq("t5_d1_dropped", 32'(d1_a_val), 32'd0);
    check_eq("t5_d0_quiet",   32'(d0_a_val), 32'd0);

    // 6: B alone for 4 cycles, then a tie goes to A
    for (int k = 0; k < 4; k++) begin
      tick();
      a_en = 1'b0; b_en = 1'b1; b_addr = 4'd2;
      #1;
      check_eq($sformatf("t6_b_only_%0d", k), 32'(d0_b_rdy), 32'd1);
    end
    tick();
    a_en = 1'b1; b_en = 1'b1;
    #1;
    check_eq("t6_tie_a", 32'(d0_a_rdy), 32'd1);
    check_eq("t6_tie_b", 32'(d0_b_rdy), 32'd0);
    tick();
    #1;
    check_eq("t6_next_b", 32'(d0_b_rdy), 32'd1);
    check_eq("t6_next_a", 32'(d0_a_rdy), 32'd0);
    tick();
    a_en = 1'b0; b_en = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
